// File: rtl/load_store_unit.sv
// Load/store unit: sub-word loads with sign/zero extension, sub-word stores via read-modify-write.
// Optional MISALIGN_TRAP_EN: trap misaligned halfword/word accesses instead of force-aligning them.
module load_store_unit #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] address,
    output logic [31:0] writeData,
    input  logic [31:0] readData
);

    typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;

    localparam logic [1:0]  SZ_B      = 2'b00;
    localparam logic [1:0]  SZ_H      = 2'b01;
    localparam logic [1:0]  SZ_W      = 2'b10;
    localparam logic [1:0]  SZ_X      = 2'b11;
    localparam logic [31:0] ADDR_MASK = 32'(MEM_WORDS * 4 - 1);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        misaligned;
    logic        illegal;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] merged;

`ifdef MISALIGN_TRAP_EN
    assign misaligned = ((req_size == SZ_H) && req_addr[0]) ||
                        ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign illegal = (req_size == SZ_X) || misaligned;

    // Lane extraction uses only the naturally aligned low address bits.
    always_comb begin
        byte_sel = readData[{addr_q[1:0], 3'b000} +: 8];
        half_sel = addr_q[1] ? readData[31:16] : readData[15:0];
        case (size_q)
            SZ_B:    load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            SZ_H:    load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_ext = readData;
        endcase
    end

    always_comb begin
        merged = merge_q;
        if (size_q == SZ_B) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        uns_d    = uns_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        merge_d  = merge_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        MemRead  = 1'b0;
        MemWrite = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = 32'h0;
                    err_d   = illegal;
                    if (illegal)             state_d = RESP;
                    else if (!req_we)        state_d = LOAD;
                    else if (req_size == SZ_W) state_d = STORE;
                    else                     state_d = RMW_RD;
                end
            end
            LOAD: begin
                MemRead = 1'b1;
                rdata_d = load_ext;
                state_d = RESP;
            end
            STORE: begin
                MemWrite = 1'b1;
                state_d  = RESP;
            end
            RMW_RD: begin
                MemRead = 1'b1;
                merge_d = readData;
                state_d = RMW_WR;
            end
            RMW_WR: begin
                MemWrite = 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobe-side outputs are decoded from the current state so reset silences them at once.
    assign address    = (MemRead || MemWrite) ? ({addr_q[31:2], 2'b00} & ADDR_MASK) : 32'h0;
    assign writeData  = (state_q == STORE)  ? wdata_q :
                        (state_q == RMW_WR) ? merged  : 32'h0;
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // NOTE: sequential state uses non-blocking assignments only; all next values come from the comb block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            merge_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 256-word data memory.
// Expected values are hand-computed; MISALIGN_TRAP_EN selects the misalignment expectations.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [0:255];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          both_cnt = 0;
    logic [31:0] last_waddr = 32'h0;
    logic [31:0] last_wdata = 32'h0;

    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          rd_n;
    int          wr_n;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(256)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .MemRead(MemRead), .MemWrite(MemWrite), .address(address),
        .writeData(writeData), .readData(readData)
    );

    assign readData = MemRead ? mem[address[9:2]] : 32'h0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    end

    always @(posedge clk) begin
        if (MemRead) rd_cnt <= rd_cnt + 1;
        if (MemRead && MemWrite) both_cnt <= both_cnt + 1;
        if (MemWrite) begin
            wr_cnt     <= wr_cnt + 1;
            last_waddr <= address;
            last_wdata <= writeData;
            mem[address[9:2]] <= writeData;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one request, measures acceptance-edge-to-resp_valid latency, optionally stalls resp_ready.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input int stall);
        int rd0;
        int wr0;
        @(negedge clk);
        check("req_ready_idle", {31'h0, req_ready}, 32'h1);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (stall == 0) req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (resp_valid !== 1'b1) begin
            check("resp_timeout", 32'h0, 32'h1);
            req_valid = 1'b0;
            rdata = 32'hx;
            err = 1'bx;
            rd_n = -1;
            wr_n = -1;
            return;
        end
        rdata = resp_rdata;
        err   = resp_err;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", {31'h0, resp_valid}, 32'h1);
            check("stall_rdata", resp_rdata, rdata);
            check("stall_ready", {31'h0, req_ready}, 32'h0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        rd_n = rd_cnt - rd0;
        wr_n = wr_cnt - wr0;
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_err", {31'h0, resp_err}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_strobes", {30'h0, MemRead, MemWrite}, 32'h0);
        check("rst_address", address, 32'h0);
        check("rst_wdata", writeData, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Word store then word load
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0);
        check("sw_lat", lat, 2);
        check("sw_wr_cycles", wr_n, 1);
        check("sw_rd_cycles", rd_n, 0);
        check("sw_addr", last_waddr, 32'h10);
        check("sw_wdata", last_wdata, 32'hDEADBEEF);
        check("sw_rdata", rdata, 32'h0);
        check("sw_err", {31'h0, err}, 32'h0);

        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
        check("lw_lat", lat, 2);
        check("lw_rd_cycles", rd_n, 1);
        check("lw_rdata", rdata, 32'hDEADBEEF);
        check("lw_err", {31'h0, err}, 32'h0);

        // Sub-word loads with sign/zero extension
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 0);
        do_req(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 0);
        check("lb_23", rdata, 32'h00000011);
        do_req(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 0);
        check("lb_20", rdata, 32'h00000044);

        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h80001234, 0);
        do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 0);
        check("lh_22_signed", rdata, 32'hFFFF8000);
        do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 0);
        check("lhu_22", rdata, 32'h00008000);
        do_req(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 0);
        check("lh_20_signed", rdata, 32'h00001234);

        // Byte and halfword stores via read-modify-write
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 0);
        do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFFAB, 0);
        check("sb_lat", lat, 3);
        check("sb_rd_cycles", rd_n, 1);
        check("sb_wr_cycles", wr_n, 1);
        check("sb_addr", last_waddr, 32'h20);
        check("sb_wdata", last_wdata, 32'h1122AB44);
        check("sb_rdata", rdata, 32'h0);
        check("sb_mem", mem[8], 32'h1122AB44);

        do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000CAFE, 0);
        check("sh_lat", lat, 3);
        check("sh_wdata", last_wdata, 32'hCAFEAB44);
        do_req(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 0);
        check("lb_23_neg", rdata, 32'hFFFFFFCA);
        do_req(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 0);
        check("lbu_23", rdata, 32'h000000CA);

        // Misaligned halfword load
        do_req(1'b1, 2'b10, 1'b0, 32'h30, 32'h55667788, 0);
        do_req(1'b0, 2'b01, 1'b1, 32'h31, 32'h0, 0);
`ifdef MISALIGN_TRAP_EN
        check("mis_lat", lat, 1);
        check("mis_err", {31'h0, err}, 32'h1);
        check("mis_rdata", rdata, 32'h0);
        check("mis_strobes", rd_n + wr_n, 0);
`else
        check("mis_lat", lat, 2);
        check("mis_err", {31'h0, err}, 32'h0);
        check("mis_rdata", rdata, 32'h00007788);
`endif

        // Illegal size
        do_req(1'b1, 2'b11, 1'b0, 32'h10, 32'h12345678, 0);
        check("ill_lat", lat, 1);
        check("ill_err", {31'h0, err}, 32'h1);
        check("ill_rdata", rdata, 32'h0);
        check("ill_strobes", rd_n + wr_n, 0);
        check("ill_mem_intact", mem[4], 32'hDEADBEEF);

        // Response back-pressure with a request held on req_valid throughout
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5);
        check("stall_result", rdata, 32'hDEADBEEF);
        check("stall_one_read", rd_n, 1);

        // Address wrap beyond MEM_WORDS*4
        do_req(1'b1, 2'b10, 1'b0, 32'h414, 32'h12345678, 0);
        check("wrap_addr", last_waddr, 32'h14);
        do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 0);
        check("wrap_load", rdata, 32'h12345678);

        // Reset during RMW_RD
        do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h0BADF00D, 0);
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'h000000EE; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rmw_rd_read", {31'h0, MemRead}, 32'h1);
        check("rmw_rd_nowrite", {31'h0, MemWrite}, 32'h0);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_strobes", {30'h0, MemRead, MemWrite}, 32'h0);
        check("rst_mid_address", address, 32'h0);
        check("rst_mid_ready", {31'h0, req_ready}, 32'h1);
        check("rst_mid_valid", {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_resp", {31'h0, resp_valid}, 32'h0);
        end
        check("rst_mem_intact", mem[16], 32'h0BADF00D);
        do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0);
        check("post_rst_load", rdata, 32'h0BADF00D);

        check("strobe_exclusive", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
